// File: rtl/spi_flash_reader_pkg.sv
// Shared state encoding and SPI flash command constants for spi_flash_reader.
// The DUMMY state exists only when SPI_FAST_READ_EN is defined.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
`ifdef SPI_FAST_READ_EN
        ST_DUMMY,
`endif
        ST_DATA,
        ST_STALL,
        ST_FINISH
    } state_t;

    localparam logic [7:0]  OP_READ      = 8'h03;
    localparam logic [7:0]  OP_FAST_READ = 8'h0B;
    localparam int unsigned ADDR_W       = 24;
    localparam int unsigned DUMMY_BITS   = 8;

endpackage

// File: rtl/spi_flash_reader_if.sv
// Request / word-stream bus between spi_flash_reader and its host and consumer.
interface spi_flash_reader_if
    import spi_flash_pkg::*;
#(
    parameter int unsigned WORD_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [15:0]       byte_count;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output start, start_addr, byte_count, data_ready,
        input  busy, done, data_out, data_valid
    );

    modport slave (
        input  start, start_addr, byte_count, data_ready,
        output busy, done, data_out, data_valid
    );
endinterface

// File: rtl/spi_flash_reader_sclk_gen.sv
// SPI mode-0 clock generator: CLK_DIV clk cycles per half period, with
// one-cycle rise/fall strobes. Pause holds SCLK low once it has fallen.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_pause,
    output logic spi_sclk,
    output logic rise_en,
    output logic fall_en
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          w_term;

    assign w_term   = (r_cnt == CW'(CLK_DIV - 1));
    assign rise_en  = i_run && !i_pause && w_term && !r_sclk;
    assign fall_en  = i_run && w_term && r_sclk;
    assign spi_sclk = r_sclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_run) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (rise_en || fall_en) begin
            r_cnt  <= '0;
            r_sclk <= !r_sclk;
        end else if (!(i_pause && !r_sclk)) begin
            // a pause requested while SCLK is high still lets the fall happen
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash bulk reader: READ (or FAST_READ with SPI_FAST_READ_EN) + 24-bit
// address, then byte_count bytes packed MSB-first into WORD_W-bit words.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_HIGH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    spi_flash_reader_if.slave       bus,
    output logic                    spi_cs_n,
    output logic                    spi_sclk,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);
    localparam int unsigned WB  = WORD_W / 8;
    localparam int unsigned IW  = (WB > 1) ? $clog2(WB) : 1;
    localparam int unsigned CCW = $clog2(CS_HIGH + 1) + 1;
`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] OPCODE = OP_FAST_READ;
`else
    localparam logic [7:0] OPCODE = OP_READ;
`endif

    state_t            r_state, w_next;
    logic              r_cs_n, r_mosi, r_valid, r_done, r_pend_vld;
    logic [31:0]       r_tx;
    logic [4:0]        r_bitcnt;
    logic [6:0]        r_byte;
    logic [IW-1:0]     r_idx;
    logic [15:0]       r_left;
    logic [CCW-1:0]    r_cs_cnt;
    logic [WORD_W-1:0] r_acc, r_pend, r_data_out;

    logic              w_run, w_pause, w_rise, w_fall;
    logic              w_byte_end, w_last, w_word_end, w_out_free, w_finish_ok;
    logic [7:0]        w_byte;
    logic [WORD_W-1:0] w_word;

    assign w_run       = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign w_pause     = (r_state == ST_STALL);
    assign w_byte      = {r_byte, spi_miso};
    assign w_byte_end  = (r_state == ST_DATA) && w_rise && (r_bitcnt[2:0] == 3'd7);
    assign w_last      = (r_left == 16'd1);
    assign w_word_end  = w_byte_end && (w_last || (r_idx == IW'(WB - 1)));
    assign w_out_free  = !r_valid || bus.data_ready;
    assign w_finish_ok = r_cs_n && (r_cs_cnt == CCW'(CS_HIGH)) && !r_valid && !r_pend_vld;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk      (clk),
        .reset    (reset),
        .i_run    (w_run),
        .i_pause  (w_pause),
        .spi_sclk (spi_sclk),
        .rise_en  (w_rise),
        .fall_en  (w_fall)
    );

    always_comb begin
        w_word = r_acc;
        for (int unsigned b = 0; b < WB; b++) begin
            if (r_idx == IW'(b)) w_word[WORD_W-8-8*b +: 8] = w_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.start && (bus.byte_count != '0)) w_next = ST_CMD;
            ST_CMD:    if (w_rise && (r_bitcnt == 5'd7)) w_next = ST_ADDR;
`ifdef SPI_FAST_READ_EN
            ST_ADDR:   if (w_rise && (r_bitcnt == 5'(ADDR_W - 1))) w_next = ST_DUMMY;
            ST_DUMMY:  if (w_rise && (r_bitcnt == 5'(DUMMY_BITS - 1))) w_next = ST_DATA;
`else
            ST_ADDR:   if (w_rise && (r_bitcnt == 5'(ADDR_W - 1))) w_next = ST_DATA;
`endif
            ST_DATA: begin
                if (w_byte_end && w_last)          w_next = ST_FINISH;
                else if (w_word_end && !w_out_free) w_next = ST_STALL;
            end
            ST_STALL:  if (w_out_free) w_next = ST_DATA;
            ST_FINISH: if (w_finish_ok) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_tx       <= '0;
            r_bitcnt   <= '0;
            r_byte     <= '0;
            r_idx      <= '0;
            r_left     <= '0;
            r_cs_cnt   <= '0;
            r_acc      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_valid && bus.data_ready) r_valid <= 1'b0;
            // a word parked by backpressure moves out as soon as the register frees
            if (r_pend_vld && w_out_free) begin
                r_data_out <= r_pend;
                r_valid    <= 1'b1;
                r_pend_vld <= 1'b0;
            end
            if (w_fall) begin
                r_mosi <= r_tx[31];
                r_tx   <= {r_tx[30:0], 1'b0};
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.byte_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cs_n   <= 1'b0;
                            r_mosi   <= OPCODE[7];
                            r_tx     <= {OPCODE[6:0], bus.start_addr, 1'b0};
                            r_bitcnt <= '0;
                            r_left   <= bus.byte_count;
                            r_idx    <= '0;
                            r_acc    <= '0;
                            r_cs_cnt <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_rise) begin
                        r_byte   <= w_byte[6:0];
                        r_bitcnt <= w_byte_end ? 5'd0 : r_bitcnt + 5'd1;
                    end
                    if (w_byte_end) begin
                        r_left <= r_left - 16'd1;
                        if (w_word_end) begin
                            r_idx <= '0;
                            r_acc <= '0;
                            if (w_out_free) begin
                                r_data_out <= w_word;
                                r_valid    <= 1'b1;
                            end else begin
                                r_pend     <= w_word;
                                r_pend_vld <= 1'b1;
                            end
                        end else begin
                            r_acc <= w_word;
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                ST_STALL: ;
                ST_FINISH: begin
                    r_cs_n <= 1'b1;
                    r_mosi <= 1'b0;
                    if (r_cs_n && (r_cs_cnt != CCW'(CS_HIGH))) r_cs_cnt <= r_cs_cnt + CCW'(1);
                    if (w_finish_ok) r_done <= 1'b1;
                end
                default: begin
                    if (w_rise) r_bitcnt <= (w_next != r_state) ? 5'd0 : r_bitcnt + 5'd1;
                end
            endcase
        end
    end

    assign spi_cs_n       = r_cs_n;
    assign spi_mosi       = r_mosi;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = r_done;
    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_valid;
endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed self-checking bench for spi_flash_reader with a behavioural SPI flash
// model; follows SPI_FAST_READ_EN for the expected opcode and header length.
module tb_spi_flash_reader;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned CS_HIGH = 4;
`ifdef SPI_FAST_READ_EN
    localparam int         HDR    = 40;
    localparam logic [7:0] EXP_OP = 8'h0B;
`else
    localparam int         HDR    = 32;
    localparam logic [7:0] EXP_OP = 8'h03;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic spi_cs_n, spi_sclk, spi_mosi;
    logic spi_miso = 1'b0;

    spi_flash_reader_if #(.WORD_W(WORD_W)) bus_if ();

    spi_flash_reader #(.WORD_W(WORD_W), .CLK_DIV(CLK_DIV), .CS_HIGH(CS_HIGH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    // Flash model: captures MOSI on SCLK rise, presents data MSB-first on SCLK fall.
    logic [7:0]  flash_bytes [0:15];
    int          rise_cnt = 0;
    int          mk;
    logic [39:0] mosi_cap = '0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;

    always @(spi_sclk or spi_cs_n) begin
        if (spi_cs_n === 1'b0 && prev_cs === 1'b1) begin
            rise_cnt = 0;
            mosi_cap = '0;
        end
        if (spi_cs_n === 1'b0 && spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
            rise_cnt++;
            if (rise_cnt <= HDR) mosi_cap = {mosi_cap[38:0], spi_mosi};
        end
        if (spi_cs_n === 1'b0 && spi_sclk === 1'b0 && prev_sclk === 1'b1 && rise_cnt >= HDR) begin
            mk = rise_cnt - HDR;
            if (mk < 128) spi_miso = flash_bytes[mk/8][7-(mk%8)];
        end
        prev_cs   = spi_cs_n;
        prev_sclk = spi_sclk;
    end

    logic [WORD_W-1:0] words [$];
    always @(negedge clk) begin
        if (!reset && bus_if.data_valid && bus_if.data_ready) words.push_back(bus_if.data_out);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word_at(input int i);
        if (i < words.size()) return 64'(words[i]);
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    function automatic logic [63:0] hdr_got();
`ifdef SPI_FAST_READ_EN
        return 64'(mosi_cap[39:8]);
`else
        return 64'(mosi_cap[31:0]);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int done_cyc, first_sclk_cyc, cs_rise_cyc, busy_seen, cs_low_seen;
    int win_sclk_hi, win_rise0, win_rise1, word_base;
    logic win_valid, c1_cs, c1_mosi, c1_busy, done_after, busy_after;
    logic [WORD_W-1:0] win_data;

    // Runs one read from cycle 0 (accept); data_ready is low for cycles [lo, hi).
    task automatic run_read(input logic [23:0] a, input logic [15:0] n, input int lo, input int hi);
        word_base = words.size();
        done_cyc = -1; first_sclk_cyc = -1; cs_rise_cyc = -1;
        busy_seen = 0; cs_low_seen = 0; win_sclk_hi = 0; win_rise0 = -1; win_rise1 = -1;
        win_valid = 1'b0; win_data = '0;
        bus_if.start_addr = a;
        bus_if.byte_count = n;
        bus_if.start      = 1'b1;
        bus_if.data_ready = 1'b1;
        tick();
        bus_if.start = 1'b0;
        c1_cs = spi_cs_n; c1_mosi = spi_mosi; c1_busy = bus_if.busy;
        for (int cyc = 1; cyc <= 3000 && done_cyc < 0; cyc++) begin
            bus_if.data_ready = !(cyc >= lo && cyc < hi);
            if (spi_sclk && first_sclk_cyc < 0) first_sclk_cyc = cyc;
            if (!spi_cs_n) cs_low_seen = 1;
            if (spi_cs_n && cs_low_seen != 0 && cs_rise_cyc < 0) cs_rise_cyc = cyc;
            if (bus_if.busy) busy_seen = 1;
            if (cyc >= 420 && cyc < 450) begin
                if (spi_sclk) win_sclk_hi++;
                if (cyc == 420) win_rise0 = rise_cnt;
                if (cyc == 449) win_rise1 = rise_cnt;
                if (cyc == 430) begin
                    win_valid = bus_if.data_valid;
                    win_data  = bus_if.data_out;
                end
            end
            if (bus_if.done) done_cyc = cyc;
            else tick();
        end
        tick();
        done_after = bus_if.done;
        busy_after = bus_if.busy;
        bus_if.data_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.start = 1'b0;
        bus_if.start_addr = '0;
        bus_if.byte_count = '0;
        bus_if.data_ready = 1'b1;
        for (int i = 0; i < 16; i++) flash_bytes[i] = 8'h00;
        #2 reset = 1'b1;
        repeat (3) tick();
        check_val("rst_cs_n",  64'(spi_cs_n), 64'd1);
        check_val("rst_sclk",  64'(spi_sclk), 64'd0);
        check_val("rst_mosi",  64'(spi_mosi), 64'd0);
        check_val("rst_busy",  64'(bus_if.busy), 64'd0);
        check_val("rst_done",  64'(bus_if.done), 64'd0);
        check_val("rst_valid", 64'(bus_if.data_valid), 64'd0);
        check_val("rst_data",  64'(bus_if.data_out), 64'd0);
        reset = 1'b0;
        repeat (2) tick();

        // 4-byte read at 0x000100
        flash_bytes[0] = 8'h12; flash_bytes[1] = 8'h34; flash_bytes[2] = 8'h56; flash_bytes[3] = 8'h78;
        run_read(24'h000100, 16'd4, 0, 0);
        check_val("t1_cyc1_cs_n",  64'(c1_cs), 64'd0);
        check_val("t1_cyc1_mosi",  64'(c1_mosi), 64'(EXP_OP[7]));
        check_val("t1_cyc1_busy",  64'(c1_busy), 64'd1);
        check_val("t1_first_rise", 64'(first_sclk_cyc), 64'(1 + CLK_DIV));
        check_val("t1_header",     hdr_got(), {32'd0, EXP_OP, 24'h000100});
`ifdef SPI_FAST_READ_EN
        check_val("t1_dummy_mosi", 64'(mosi_cap[7:0]), 64'd0);
`endif
        check_val("t1_sclk_rises", 64'(rise_cnt), 64'(HDR + 32));
        check_val("t1_nwords",     64'(words.size() - word_base), 64'd1);
        check_val("t1_word0",      word_at(word_base), 64'h12345678);
        check_val("t1_done_seen",  64'(done_cyc > 0), 64'd1);
        check_val("t1_cs_to_done", 64'((done_cyc - cs_rise_cyc) >= int'(CS_HIGH + 1)), 64'd1);
        check_val("t1_done_pulse", 64'(done_after), 64'd0);
        check_val("t1_busy_after", 64'(busy_after), 64'd0);
        repeat (3) tick();

        // 6 bytes: full word then partial word zero-filled
        flash_bytes[0] = 8'hAA; flash_bytes[1] = 8'hBB; flash_bytes[2] = 8'hCC;
        flash_bytes[3] = 8'hDD; flash_bytes[4] = 8'hEE; flash_bytes[5] = 8'hFF;
        run_read(24'hABCDEF, 16'd6, 0, 0);
        check_val("t2_header",     hdr_got(), {32'd0, EXP_OP, 24'hABCDEF});
        check_val("t2_nwords",     64'(words.size() - word_base), 64'd2);
        check_val("t2_word0",      word_at(word_base), 64'hAABBCCDD);
        check_val("t2_word1",      word_at(word_base + 1), 64'hEEFF0000);
        check_val("t2_data_rises", 64'(rise_cnt - HDR), 64'd48);
        repeat (3) tick();

        // 12 bytes with data_ready low for cycles 250..449
        for (int i = 0; i < 12; i++) flash_bytes[i] = 8'(i + 1);
        run_read(24'h000010, 16'd12, 250, 450);
        check_val("t3_stall_sclk_hi", 64'(win_sclk_hi), 64'd0);
        check_val("t3_stall_rises",   64'(win_rise1 - win_rise0), 64'd0);
        check_val("t3_stall_valid",   64'(win_valid), 64'd1);
        check_val("t3_stall_data",    64'(win_data), 64'h01020304);
        check_val("t3_nwords",        64'(words.size() - word_base), 64'd3);
        check_val("t3_word0",         word_at(word_base), 64'h01020304);
        check_val("t3_word1",         word_at(word_base + 1), 64'h05060708);
        check_val("t3_word2",         word_at(word_base + 2), 64'h090A0B0C);
        check_val("t3_sclk_rises",    64'(rise_cnt), 64'(HDR + 96));
        repeat (3) tick();

        // zero-length request
        run_read(24'h000000, 16'd0, 0, 0);
        check_val("t4_done_cyc",   64'(done_cyc), 64'd1);
        check_val("t4_busy_seen",  64'(busy_seen), 64'd0);
        check_val("t4_cs_low",     64'(cs_low_seen), 64'd0);
        check_val("t4_done_pulse", 64'(done_after), 64'd0);
        repeat (3) tick();

        // reset asserted mid-address, then a clean read
        bus_if.start_addr = 24'h123456;
        bus_if.byte_count = 16'd4;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        repeat (58) tick();
        check_val("t5_pre_cs_n", 64'(spi_cs_n), 64'd0);
        check_val("t5_pre_sclk", 64'(spi_sclk), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_val("t5_rst_cs_n",  64'(spi_cs_n), 64'd1);
        check_val("t5_rst_sclk",  64'(spi_sclk), 64'd0);
        check_val("t5_rst_busy",  64'(bus_if.busy), 64'd0);
        check_val("t5_rst_valid", 64'(bus_if.data_valid), 64'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        flash_bytes[0] = 8'h9A; flash_bytes[1] = 8'hBC; flash_bytes[2] = 8'hDE; flash_bytes[3] = 8'hF0;
        run_read(24'h000200, 16'd4, 0, 0);
        check_val("t5_header", hdr_got(), {32'd0, EXP_OP, 24'h000200});
        check_val("t5_nwords", 64'(words.size() - word_base), 64'd1);
        check_val("t5_word0",  word_at(word_base), 64'h9ABCDEF0);
        check_val("t5_done",   64'(done_cyc > 0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Parametrised SPI-flash bulk reader, the successor to the fixed 32-bit `spi_block` flash reader. It issues a READ command (or FAST_READ when enabled) with a 24-bit start address, then streams `byte_count` bytes, packed into `WORD_W`-bit words, to a valid/ready consumer. It sits between the system clock domain and the flash pins; the top level routes `spi_sclk` to STARTUPE2 `USRCCLKO`. Unlike its predecessor it has programmable length, word width, SCLK divider and consumer backpressure.

## Interface
- `WORD_W`, 32: output word width; a multiple of 8, from 8 to 64.
- `CLK_DIV`, 2: clk cycles per SCLK half-period; at least 1.
- `CS_HIGH`, 4: minimum clk cycles `spi_cs_n` stays high after a transaction.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `start_addr`  in  24  flash byte address; sampled on accept.
- `byte_count`  in  16  number of bytes to read; sampled on accept.
- `busy`  out  1  high from accept until `done`.
- `done`  out  1  one-cycle pulse at transaction end.
- `data_out`  out  WORD_W  word; first byte in the MSBs.
- `data_valid`  out  1  `data_out` holds an unaccepted word.
- `data_ready`  in  1  consumer accepts when `data_valid && data_ready`.
- `spi_cs_n`  out  1  flash chip select, active low.
- `spi_sclk`  out  1  SPI clock, mode 0 (idles low).
- `spi_mosi`  out  1  command/address, MSB first.
- `spi_miso`  in  1  flash data.

## Operation
- Reset values: `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `busy`=0, `done`=0, `data_valid`=0, `data_out`=0. Reset forces these values immediately at any point, including mid-transaction. Reset leaves no partial word behind.
- States: IDLE, CMD (8 bits), ADDR (24 bits), DUMMY (8 clocks, FAST_READ only), DATA, STALL, FINISH.
- IDLE, `start`=1, `byte_count`=0: no CS activity; `done` pulses on the next cycle; `busy` stays 0.
- IDLE, `start`=1, `byte_count`≠0: go to CMD and set `busy`=1. `start` is ignored while busy.
- Opcode is 0x03. Address bits follow the opcode, MSB first.
- DATA: `spi_miso` is shifted in MSB first. Bytes pack from `data_out[WORD_W-1:WORD_W-8]` downward.
- A word is complete after WORD_W bits, or after the last byte. In a partial final word the unfilled low bytes are 0.
- A completed word moves to the output register when `data_valid`=0 or the output word is accepted that same cycle. Otherwise the block enters STALL: SCLK is held low and no bits are lost. It resumes DATA the cycle after the output register frees.
- After the last bit is sampled, go to FINISH: `spi_cs_n`=1 and SCLK low.
- FINISH ends when both hold: CS_HIGH cycles have elapsed and the last word has been accepted. Then `done` pulses, `busy`=0, and the state returns to IDLE.
- The address counter is 24-bit. A read past 0xFFFFFF wraps in the flash; the block takes no action.

## Timing
- Accept is at cycle 0. At cycle 1, `spi_cs_n`=0 and `spi_mosi`= opcode bit 7.
- SCLK period is 2·CLK_DIV clk cycles. The first SCLK rise comes CLK_DIV cycles after `spi_cs_n` falls.
- `spi_mosi` changes only on the cycle SCLK is driven low.
- `spi_miso` is sampled on the clk edge that drives SCLK 0→1.
- `data_valid` rises one cycle after the word's final bit is sampled.
- Without backpressure, a 4-byte read at CLK_DIV=2 takes 64 SCLK cycles with CS low: 32 command/address plus 32 data.
- `done` comes at least CS_HIGH+1 cycles after `spi_cs_n` rises.

## Configuration
- Macro `SPI_FAST_READ_EN`.
- Defined: opcode 0x0B, then 8 dummy SCLK cycles after the address (MOSI=0, MISO ignored), then data.
- Undefined: opcode 0x03, the DUMMY state does not exist, and the logic is removed.

## Structure
- Package `spi_flash_pkg`:
  - state enum;
  - `OP_READ`=8'h03 and `OP_FAST_READ`=8'h0B;
  - `ADDR_W`=24 and `DUMMY_BITS`=8.
- Sub-module `spi_sclk_gen`: CLK_DIV half-period counter with a pause input. It outputs `spi_sclk` plus one-cycle `rise_en`/`fall_en` strobes. All shift and sample logic runs on these strobes.

## Test plan
- WORD_W=32, CLK_DIV=2, addr 0x000100, count 4, flash bytes 12 34 56 78:
  - MOSI carries 03 00 01 00;
  - one word 0x12345678 with `data_valid`;
  - `done` follows.
- Count 6, bytes AA BB CC DD EE FF: words 0xAABBCCDD then 0xEEFF0000; exactly 48 data SCLK rises.
- `data_ready`=0 for 200 cycles during a count-12 read:
  - SCLK is held low, with no pulses, once the second word completes;
  - after release, all 3 words arrive intact and in order.
- `start` with count 0: `done` pulses on cycle 1; `spi_cs_n` stays 1 throughout.
- `reset` asserted mid-ADDR:
  - `spi_cs_n`=1 and `spi_sclk`=0 in the same cycle;
  - a following start with count 4 returns correct data.
- With `SPI_FAST_READ_EN`: MOSI is 0B + address, then 8 dummy clocks; data begins on SCLK rise 41.
